// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon decoder chain.
// Field polynomial 0x11D, alpha = 0x02, DVB-T RS(204,188) defaults.
package rs_pkg;

  localparam int unsigned GF_W    = 8;
  localparam logic [7:0]  GF_POLY = 8'h1D;

  localparam int unsigned N = 204;
  localparam int unsigned K = 188;
  localparam int unsigned T = 8;

  // Multiply by alpha: shift left, fold x^8 back through the polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // alpha^(e mod 255), usable in constant expressions.
  function automatic logic [7:0] gf_alpha_pow(input int unsigned e);
    logic [7:0] p;
    p = 8'h01;
    for (int unsigned k = 0; k < (e % 255); k++) p = gf_xtime(p);
    return p;
  endfunction

endpackage

// File: rtl/rs_syndrome_engine_if.sv
// Byte stream in / syndrome bank out between the framer and key-equation solver.
interface rs_syndrome_engine_if #(
  parameter int unsigned NUM_SYN = 16
);
  logic                   In_Valid;
  logic                   In_Sof;
  logic [7:0]             Msg_Rsv;
  logic                   Out_Valid;
  logic [8*NUM_SYN-1:0]   Syn_Out;
  logic                   Err_Free;
  logic                   Frame_Err;

  modport master (
    output In_Valid, In_Sof, Msg_Rsv,
    input  Out_Valid, Syn_Out, Err_Free, Frame_Err
  );

  modport slave (
    input  In_Valid, In_Sof, Msg_Rsv,
    output Out_Valid, Syn_Out, Err_Free, Frame_Err
  );
endinterface

// File: rtl/gf256_const_mul.sv
// Combinational GF(2^8) multiply by the constant alpha^EXP.
// Column j of the XOR matrix is alpha^(EXP+j), the image of basis element x^j.
module gf256_const_mul
  import rs_pkg::*;
#(
  parameter int unsigned EXP = 0
) (
  input  logic [GF_W-1:0] a,
  output logic [GF_W-1:0] y_c
);

  logic [GF_W-1:0] term [GF_W];

  for (genvar j = 0; j < GF_W; j++) begin : g_col
    localparam logic [GF_W-1:0] COL = gf_alpha_pow(EXP + j);
    assign term[j] = a[j] ? COL : '0;
  end

  always_comb begin
    y_c = '0;
    for (int j = 0; j < GF_W; j++) y_c = y_c ^ term[j];
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Framed RS syndrome calculator: Horner accumulation of NUM_SYN syndromes per
// codeword, publishing a held syndrome bank with a one-cycle valid pulse.
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int unsigned NUM_SYN = 2 * T,
  parameter int unsigned CW_LEN  = N,
  parameter int unsigned FCR     = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  rs_syndrome_engine_if.slave  bus
);

  localparam int unsigned     CNT_W = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CW_LEN - 1);

  logic [CNT_W-1:0]     cnt;
  logic [GF_W-1:0]      acc   [NUM_SYN];
  logic [GF_W-1:0]      mul_c [NUM_SYN];
  logic [8*NUM_SYN-1:0] step_c;
  logic                 zero_c;
  logic                 idle_c;
  logic                 last_c;

  for (genvar i = 0; i < NUM_SYN; i++) begin : g_mul
    gf256_const_mul #(.EXP(FCR + i)) u_mul (
      .a   (acc[i]),
      .y_c (mul_c[i])
    );
  end

  // Next Horner step for every syndrome; on the last byte this is the result.
  always_comb begin
    step_c = '0;
    for (int i = 0; i < NUM_SYN; i++) step_c[8*i +: 8] = mul_c[i] ^ bus.Msg_Rsv;
    zero_c = (step_c == '0);
    idle_c = (cnt == '0);
    last_c = (cnt == LAST);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt           <= '0;
      for (int i = 0; i < NUM_SYN; i++) acc[i] <= '0;
      bus.Out_Valid <= 1'b0;
      bus.Syn_Out   <= '0;
      bus.Err_Free  <= 1'b0;
      bus.Frame_Err <= 1'b0;
    end else begin
      bus.Out_Valid <= 1'b0;
      bus.Frame_Err <= 1'b0;
      if (bus.In_Valid && bus.In_Sof) begin
        // SOF always (re)starts a frame; mid-frame it also flags the abort.
        for (int i = 0; i < NUM_SYN; i++) acc[i] <= bus.Msg_Rsv;
        cnt           <= CNT_W'(1);
        bus.Frame_Err <= !idle_c;
      end else if (bus.In_Valid) begin
        if (idle_c) begin
          bus.Frame_Err <= 1'b1;
        end else if (last_c) begin
          bus.Syn_Out   <= step_c;
          bus.Err_Free  <= zero_c;
          bus.Out_Valid <= 1'b1;
          cnt           <= '0;
        end else begin
          for (int i = 0; i < NUM_SYN; i++) acc[i] <= step_c[8*i +: 8];
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/rs_syndrome_engine.md
Name: rs_syndrome_engine

Overview:
- Parametrised, framed Reed-Solomon syndrome calculator for the RS decoder chain. Default configuration is DVB-T RS(204,188), t=8.
- Accumulates NUM_SYN syndromes over GF(2^8) by Horner's rule, one received byte per valid cycle.
- Tracks codeword boundaries with a byte counter and detects framing errors.
- Publishes a held, double-buffered syndrome bank with a one-cycle valid pulse and an error-free flag to the downstream key-equation solver.

Parameters:
- NUM_SYN, 16, number of syndromes (2t). Range 2..32.
- CW_LEN, 204, codeword length in bytes. Range 2..255.
- FCR, 0, exponent of the first generator root. Syndrome i uses root alpha^(FCR+i), i=0..NUM_SYN-1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset. Reset=0 clears all state immediately.
- In_Valid  in  1  Msg_Rsv carries a byte this cycle.
- In_Sof  in  1  first byte of a codeword. Qualified by In_Valid.
- Msg_Rsv  in  8  received byte, highest-degree coefficient first.
- Out_Valid  out  1  one-cycle pulse: Syn_Out and Err_Free updated.
- Syn_Out  out  8*NUM_SYN  syndrome bank. S_i occupies bits [8i+7:8i].
- Err_Free  out  1  1 when every syndrome in Syn_Out is zero.
- Frame_Err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02.
- Reset values: Out_Valid=0, Syn_Out=0, Err_Free=0, Frame_Err=0. Byte counter=0 (IDLE). Accumulators=0.
- State is implied by the counter: cnt=0 is IDLE; 1..CW_LEN-1 is ACCUM.
- IDLE:
  - In_Valid & In_Sof: acc_i <= Msg_Rsv for all i, cnt <= 1.
  - In_Valid & !In_Sof: byte dropped, Frame_Err pulses the next cycle, stay IDLE.
- ACCUM, In_Valid & !In_Sof: acc_i <= acc_i*alpha^(FCR+i) XOR Msg_Rsv, cnt <= cnt+1.
- ACCUM, In_Valid & In_Sof (early SOF): Frame_Err pulses. The partial frame is discarded with no Out_Valid. The new frame restarts exactly as the IDLE SOF case.
- ACCUM, In_Valid=0: accumulators and counter hold. Gaps of any length are allowed.
- Last byte (In_Valid, !In_Sof, cnt=CW_LEN-1):
  - The final Horner step is computed combinationally and loaded directly into Syn_Out; accumulators are not updated.
  - Err_Free <= (all final values == 0). Out_Valid=1 the next cycle. cnt <= 0.
- Latency: Out_Valid rises on the clock edge that samples the last byte, i.e. it is visible in the cycle after that byte.
- Syn_Out and Err_Free hold until the next completed frame. Downstream may read them while the following frame accumulates.
- Back-to-back: a SOF in the cycle immediately after the last byte is legal and starts the next frame with no bubble.
- Reset asserted mid-frame: everything clears, including Syn_Out. Bytes received before reset never produce Out_Valid.
- Arithmetic: constant multipliers only. All XORs are 8-bit. No carries or overflow; counter width is ceil(log2(CW_LEN)).

Decomposition:
- Shared package rs_pkg holds:
  - GF_POLY = 8'h1D and GF_W = 8.
  - A constant function gf_alpha_pow(e) returning alpha^(e mod 255).
  - The DVB-T defaults N=204, K=188, T=8.
- Sub-module gf256_const_mul, parameter EXP: combinational multiply of an 8-bit input by alpha^EXP, built from the XOR matrix derived with gf_alpha_pow.
- The top level instantiates NUM_SYN copies of gf256_const_mul in a generate loop.

Test Plan:
- All-zero codeword, 204 contiguous bytes with SOF on byte 0: Out_Valid 1 cycle after byte 203, Syn_Out all 0x00, Err_Free=1, Frame_Err never asserts.
- Zero codeword with last byte 0x01 (degree-0 error): every S_i=0x01, Err_Free=0.
- Zero codeword with byte 202 = 0x01 (degree 1): S_i=alpha^i, i.e. S_0=0x01, S_1=0x02, S_7=0x80, S_8=0x1D, S_15=0x26 (FCR=0).
- Repeat the degree-1 case with random In_Valid gaps of 0..5 cycles: identical Syn_Out, and Out_Valid only after the 204th valid byte.
- Framing errors:
  - SOF inserted at byte 100 of a frame: Frame_Err pulses once, no Out_Valid for the aborted frame, and the restarted frame's syndromes match a clean run.
  - Valid bytes without SOF in IDLE: Frame_Err pulses and the bytes are ignored.
- Back-to-back error-free and errored frames with no gap: two Out_Valid pulses exactly 204 cycles apart, with correct values each.
- Reset driven low at byte 150: all outputs 0 within the same cycle. A following clean frame produces correct syndromes.
